// File: rtl/stream_upsizer.sv
// Valid-ready width converter: packs OUT_WIDTH/IN_WIDTH narrow beats into one wide word.
// An input last flag closes a partial word early; data_out_keep_o marks the filled lanes.
module stream_upsizer #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                             clk_i,
    input  logic                             arst_ni,
    input  logic [IN_WIDTH-1:0]              data_in_i,
    input  logic                             data_in_last_i,
    input  logic                             data_in_valid_i,
    output logic                             data_in_ready_o,
    output logic [OUT_WIDTH-1:0]             data_out_o,
    output logic [OUT_WIDTH/IN_WIDTH-1:0]    data_out_keep_o,
    output logic                             data_out_last_o,
    output logic                             data_out_valid_o,
    input  logic                             data_out_ready_i
);

    localparam int unsigned RATIO = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LastLane = CW'(RATIO - 1);

    if (((OUT_WIDTH % IN_WIDTH) != 0) || (RATIO < 2)) begin : g_param_check
        $fatal(1, "stream_upsizer: OUT_WIDTH must be a multiple (>=2x) of IN_WIDTH");
    end

    logic [CW-1:0]        count_q, count_d;
    logic [OUT_WIDTH-1:0] asm_data_q, asm_data_d;
    logic [RATIO-1:0]     asm_keep_q, asm_keep_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]     out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;
    logic                 out_valid_q, out_valid_d;

    logic                 in_fire;
    logic                 complete;
    logic [OUT_WIDTH-1:0] merged_data;
    logic [RATIO-1:0]     merged_keep;

    assign data_in_ready_o  = !out_valid_q | data_out_ready_i;
    assign data_out_o       = out_data_q;
    assign data_out_keep_o  = out_keep_q;
    assign data_out_last_o  = out_last_q;
    assign data_out_valid_o = out_valid_q;

    always_comb begin
        in_fire  = data_in_valid_i & data_in_ready_o;
        complete = in_fire & (data_in_last_i | (count_q == LastLane));

        // Assembly lanes are cleared on completion, so unwritten lanes are already zero.
        merged_data = asm_data_q;
        merged_keep = asm_keep_q;
        for (int k = 0; k < RATIO; k++) begin
            if (count_q == CW'(k)) begin
                merged_data[k*IN_WIDTH +: IN_WIDTH] = data_in_i;
                merged_keep[k]                      = 1'b1;
            end
        end

        count_d     = count_q;
        asm_data_d  = asm_data_q;
        asm_keep_d  = asm_keep_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && data_out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (complete) begin
            out_data_d  = merged_data;
            out_keep_d  = merged_keep;
            out_last_d  = data_in_last_i;
            out_valid_d = 1'b1;
            asm_data_d  = '0;
            asm_keep_d  = '0;
            count_d     = '0;
        end else if (in_fire) begin
            asm_data_d = merged_data;
            asm_keep_d = merged_keep;
            count_d    = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            count_q     <= '0;
            asm_data_q  <= '0;
            asm_keep_q  <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            asm_data_q  <= asm_data_d;
            asm_keep_q  <= asm_keep_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Valid-ready stream width converter: packs RATIO = OUT_WIDTH/IN_WIDTH narrow input beats into one wide output word.
- Sits directly upstream of a DATA_WIDTH-wide consumer. It lets a narrow producer (byte/halfword source) feed a wide datapath.
- An input `last` flag closes a partially filled word early. Lane-valid mask is `data_out_keep_o`.

Parameters:
- IN_WIDTH, 8, input beat width in bits.
- OUT_WIDTH, 32, output word width in bits; must be an integer multiple of IN_WIDTH.
- RATIO (localparam), OUT_WIDTH/IN_WIDTH, lanes per output word; must be ≥2.
- CW (localparam), $clog2(RATIO), lane counter width.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- arst_ni  input  1  asynchronous active-low reset.
- data_in_i  input  IN_WIDTH  input beat.
- data_in_last_i  input  1  beat is last of packet; closes current word.
- data_in_valid_i  input  1  input beat valid.
- data_in_ready_o  output  1  block accepts input beat this cycle.
- data_out_o  output  OUT_WIDTH  packed word; lane 0 = bits [IN_WIDTH-1:0] = first beat.
- data_out_keep_o  output  RATIO  bit k set = lane k holds valid data.
- data_out_last_o  output  1  word closed by data_in_last_i.
- data_out_valid_o  output  1  output word valid.
- data_out_ready_i  input  1  consumer accepts word.

Behaviour:
- Reset (async assert, sync to clk_i on deassert at system level):
  - data_out_valid_o=0, data_out_o=0, data_out_keep_o=0, data_out_last_o=0.
  - Lane counter=0; assembly buffer and keep=0.
- Handshakes:
  - Input transfer when data_in_valid_i & data_in_ready_o.
  - Output transfer when data_out_valid_o & data_out_ready_i.
- data_in_ready_o = !data_out_valid_o | data_out_ready_i. Purely a function of output state and data_out_ready_i; never depends on data_in_* (no comb loop upstream).
- Accepted beat:
  - Written to assembly lane[count]; assembly keep[count] set.
  - If count==RATIO-1 or data_in_last_i: the word completes.
  - Otherwise count increments.
- Completion (same edge as the completing input transfer):
  - Output register loads the assembly data, including the current beat.
  - Unwritten lanes are driven 0.
  - data_out_keep_o is loaded from keep, data_out_last_o from data_in_last_i, and data_out_valid_o is set to 1.
  - Assembly keep clears and count returns to 0.
- Latency: word visible on outputs the cycle after the completing input beat. With no backpressure, throughput is 1 input beat/cycle and the output fires every RATIO cycles.
- Output transfer without a completing input in the same cycle: data_out_valid_o→0. Output data, keep and last hold stale values; no X requirement.
- Simultaneous output transfer and completing input: the output register reloads with the new word; data_out_valid_o stays 1 (back-to-back words).
- Partial words are never emitted without data_in_last_i. No timeout flush.
- When data_in_last_i arrives on lane RATIO-1, keep = all ones and data_out_last_o=1.
- A packet of one beat produces keep=1 (lane 0 only) and last=1.
- Outputs stay stable while data_out_valid_o=1 and data_out_ready_i=0.
- Reset asserted mid-word or mid-stall: the partial word and pending output are discarded immediately. Outputs return to reset values asynchronously.
- Elaboration check: fatal if OUT_WIDTH % IN_WIDTH != 0 or RATIO < 2.

Test Plan:
1. Full words: IN=8/OUT=32, beats 0x11,0x22,0x33,0x44 on consecutive cycles, ready_i=1.
   - Expect one cycle after the 4th beat: data_out=0x44332211, keep=4'b1111, last=0, valid for 1 cycle.
2. Partial word: beats 0xAA,0xBB with last on 0xBB.
   - Expect data_out=0x0000BBAA, keep=4'b0011, last=1.
3. Single-beat packet: 0x5C with last.
   - Expect data_out=0x0000005C, keep=4'b0001, last=1.
4. Backpressure: ready_i=0 after the first word completes, input valid held.
   - data_in_ready_o=0 and outputs stable until ready_i=1.
   - The next 4 beats then produce the second word. No beat is lost or duplicated (count 8 beats in, 2 words out).
5. Streaming: 16 random beats, ready_i=1 constant.
   - 4 words, back-to-back valid every 4 cycles, data matches in order.
6. Reset after 2 of 4 beats accepted, then deassert and send 0x01..0x04.
   - Outputs 0 during reset; next word = 0x04030201, keep=4'b1111 (no stale lanes).
